// File: rtl/reg_file.sv
// 32-entry register file with two combinational read ports and one write port.
// Register 0 always reads as zero.
module reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] read1_num,
   input  logic [ADDR_W-1:0] read2_num,
   input  logic [ADDR_W-1:0] write_num,
   input  logic [DATA_W-1:0] write_data,
   input  logic              write_en,
   output logic [DATA_W-1:0] read1_data,
   output logic [DATA_W-1:0] read2_data
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREG];

   // Entry 0 is cleared by reset and never written, so it stays constant zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en && (write_num != '0)) begin
         regs[write_num] <= write_data;
      end
   end

   // The explicit zero mux keeps r0 at zero even before the first reset.
   always_comb begin
      read1_data = (read1_num == '0) ? '0 : regs[read1_num];
      read2_data = (read2_num == '0) ? '0 : regs[read2_num];
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read timing, r0, enable, dual port, sweep.
module tb_reg_file;

   logic        clk;
   logic        rst;
   logic [4:0]  read1_num;
   logic [4:0]  read2_num;
   logic [4:0]  write_num;
   logic [31:0] write_data;
   logic        write_en;
   logic [31:0] read1_data;
   logic [31:0] read2_data;

   int checks;
   int failures;

   reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .read1_num  (read1_num),
      .read2_num  (read2_num),
      .write_num  (write_num),
      .write_data (write_data),
      .write_en   (write_en),
      .read1_data (read1_data),
      .read2_data (read2_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives a write from the preceding falling edge and leaves time at posedge+1.
   task automatic do_write(input logic [4:0] num, input logic [31:0] data);
      @(negedge clk);
      write_en   = 1'b1;
      write_num  = num;
      write_data = data;
      @(posedge clk);
      #1;
      write_en = 1'b0;
   endtask

   initial begin
      logic [31:0] exp1;
      logic [31:0] exp2;
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      read1_num  = 5'd0;
      read2_num  = 5'd0;
      write_num  = 5'd0;
      write_data = 32'h0;
      write_en   = 1'b0;

      #3;
      read1_num = 5'd5;
      read2_num = 5'd31;
      #1;
      check("reset_r5", read1_data, 32'h0);
      check("reset_r31", read2_data, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Load r5, then pulse reset mid-cycle.
      do_write(5'd5, 32'h12345678);
      read1_num = 5'd5;
      #1;
      check("r5_loaded", read1_data, 32'h12345678);
      #1 rst = 1'b1;
      #1;
      check("async_reset_r5", read1_data, 32'h0);
      rst = 1'b0;

      // Reset held across a write edge blocks it; next write then succeeds.
      @(negedge clk);
      write_en   = 1'b1;
      write_num  = 5'd9;
      write_data = 32'h99999999;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      read1_num = 5'd9;
      #1;
      check("rst_blocks_write", read1_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      write_en = 1'b0;
      #1;
      check("write_after_rst", read1_data, 32'h99999999);

      // No forwarding in the write cycle; new value after the edge.
      @(negedge clk);
      write_en   = 1'b1;
      write_num  = 5'd3;
      write_data = 32'hDEADBEEF;
      read1_num  = 5'd3;
      read2_num  = 5'd3;
      #1;
      check("r3_old_p1", read1_data, 32'h0);
      check("r3_old_p2", read2_data, 32'h0);
      @(posedge clk);
      #1;
      write_en = 1'b0;
      check("r3_new_p1", read1_data, 32'hDEADBEEF);
      check("r3_new_p2", read2_data, 32'hDEADBEEF);

      // r0 discards writes.
      do_write(5'd0, 32'hFFFFFFFF);
      read1_num = 5'd0;
      read2_num = 5'd0;
      #1;
      check("r0_p1", read1_data, 32'h0);
      check("r0_p2", read2_data, 32'h0);

      // Disabled write leaves r7 unchanged.
      @(negedge clk);
      write_en   = 1'b0;
      write_num  = 5'd7;
      write_data = 32'hCAFEBABE;
      @(posedge clk);
      #1;
      read1_num = 5'd7;
      #1;
      check("r7_no_enable", read1_data, 32'h0);

      // Two different registers on the two ports in one cycle.
      do_write(5'd1, 32'h00000011);
      do_write(5'd31, 32'hAAAA5555);
      read1_num = 5'd1;
      read2_num = 5'd31;
      #1;
      check("dual_r1", read1_data, 32'h00000011);
      check("dual_r31", read2_data, 32'hAAAA5555);

      // Sweep: r(i) = i * 0x01010101, then read all pairs.
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'(i) * 32'h01010101);
      end
      for (int k = 0; k < 16; k++) begin
         read1_num = 5'(2 * k);
         read2_num = 5'(2 * k + 1);
         exp1 = (k == 0) ? 32'h0 : 32'(2 * k) * 32'h01010101;
         exp2 = 32'(2 * k + 1) * 32'h01010101;
         #1;
         check($sformatf("sweep_r%0d", 2 * k), read1_data, exp1);
         check($sformatf("sweep_r%0d", 2 * k + 1), read2_data, exp2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and of the data ports.
REQ-002 Parameter ADDR_W, default 5, register-number width; the array holds 2**ADDR_W = 32 registers.
REQ-003 Port clk  input  1  single clock; all writes occur on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port read1_num  input  ADDR_W  register number for read port 1.
REQ-006 Port read2_num  input  ADDR_W  register number for read port 2.
REQ-007 Port write_num  input  ADDR_W  register number for the write port.
REQ-008 Port write_data  input  DATA_W  data to be written.
REQ-009 Port write_en  input  1  write enable, active-high.
REQ-010 Port read1_data  output  DATA_W  contents of register read1_num.
REQ-011 Port read2_data  output  DATA_W  contents of register read2_num.
REQ-012 The block SHALL have one clock (clk) and an asynchronous, active-high reset (rst); these are fixed and not configurable.

Function
REQ-013 Storage SHALL be 32 registers of DATA_W bits, r0..r31.
REQ-014 Read ports SHALL be combinational: read1_data and read2_data follow read1_num, read2_num and register contents with no clock latency.
REQ-015 Both read ports SHALL be independent; reading the same register on both ports in one cycle SHALL return identical data.
REQ-016 On a rising clk edge with write_en=1, rst=0 and write_num!=0, register write_num SHALL load write_data.
REQ-017 With write_en=0, no register SHALL change.
REQ-018 Register r0 SHALL be hardwired to zero: writes to r0 are discarded, and reads of r0 SHALL return 0 on either port.
REQ-019 There SHALL be no internal write-to-read forwarding: in the cycle a write is requested, reads of write_num return the old value; the new value is visible immediately after the rising edge that commits it.
REQ-020 Write latency SHALL be exactly one edge; data written at edge N SHALL be readable from edge N onward until overwritten.
REQ-021 There SHALL be no handshake, no busy state and no state machine; every cycle SHALL accept a new read and write request.
REQ-022 Out-of-range addresses SHALL NOT exist: every ADDR_W-bit value selects a valid register.
REQ-023 Outputs SHALL contain no X once rst has been asserted.

Reset
REQ-024 Asserting rst SHALL immediately, without waiting for clk, clear all 32 registers to 0; read1_data and read2_data SHALL then read 0 for every address.
REQ-025 While rst=1, writes SHALL be blocked regardless of write_en.
REQ-026 If rst asserts in the same cycle as a write, the register SHALL end at 0; after rst deasserts, the next rising edge with write_en=1 SHALL write normally.

Verification
REQ-027 Reset check: pulse rst mid-cycle after loading r5=0x12345678 -> read1_num=5 returns 0x00000000 before the next clk edge.
REQ-028 Write/read check: write r3=0xDEADBEEF with write_en=1, then read1_num=3 and read2_num=3 -> both ports return 0xDEADBEEF after the edge; in the write cycle itself they return the prior value 0x00000000.
REQ-029 r0 check: write r0=0xFFFFFFFF with write_en=1 -> read1_num=0 returns 0x00000000.
REQ-030 Enable check: write_en=0, write_num=7, write_data=0xCAFEBABE -> r7 remains at its previous value (0x00000000 after reset).
REQ-031 Dual-port check: write r1=0x00000011 and r31=0xAAAA5555, then read1_num=1 and read2_num=31 -> ports return 0x00000011 and 0xAAAA5555 respectively in the same cycle.
REQ-032 Sweep check: write r(i)=i*0x01010101 for i=1..31, then read all 32 registers pairwise -> r0 returns 0 and every other register returns its written value.
